// File: rtl/matrix_dot_scheduler_pkg.sv
// Shared word width, qNaN filler and FSM encoding for the matrix dot scheduler.
package matrix_dot_scheduler_pkg;
    localparam int          WORD_WIDTH = 32;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;
endpackage

// File: rtl/matrix_word_buffer.sv
// NxN word register file: one synchronous write port, RP combinational read ports.
// Storage has no reset; contents survive rst and are simply overwritten on the next load.
module matrix_word_buffer
    import matrix_dot_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int RP = N,
    localparam int AW = $clog2(N * N)
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [AW-1:0]                   wr_addr,
    input  logic [WORD_WIDTH-1:0]           wr_data,
    input  logic [RP-1:0][AW-1:0]           rd_addr,
    output logic [RP-1:0][WORD_WIDTH-1:0]   rd_data
);
    logic [WORD_WIDTH-1:0] mem [N*N];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < RP; k++) rd_data[k] = mem[rd_addr[k]];
    end
endmodule

// File: rtl/matrix_dot_scheduler.sv
// Loads A and B, issues every (row i, column j) pair to one inner-product unit, streams C row-major.
// Latency per dot: 2 issue cycles + inner-product latency + 1 store cycle. All ports are stb/ack;
// every stage stalls until its ack. Optional watchdog under DOT_TIMEOUT_EN.
module matrix_dot_scheduler
    import matrix_dot_scheduler_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             ld_data,
    input  logic                    ld_sel,
    input  logic                    ld_stb,
    output logic                    ld_ack,
    output logic [32*N-1:0]         ip_row,
    output logic [32*N-1:0]         ip_column,
    output logic                    ip_row_o_stb,
    output logic                    ip_column_o_stb,
    input  logic                    ip_row_i_ack,
    input  logic                    ip_column_i_ack,
    input  logic [31:0]             ip_out,
    input  logic                    ip_out_i_stb,
    output logic                    ip_out_o_ack,
    output logic [31:0]             c_out_data,
    output logic                    c_out_stb,
    input  logic                    c_out_ack,
    output logic                    busy,
    output logic                    dot_timeout
);
    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int CW = AW + 1;
    localparam int JW = $clog2(N);

    state_t          state, state_nxt;
    logic [CW-1:0]   a_cnt, b_cnt;
    logic [JW-1:0]   i_q, j_q;
    logic [AW-1:0]   idx_q;
    logic            row_done, col_done, drain_gap;

    logic a_full, b_full, ld_take, res_take, store, wd_fire, last_pair, c_take, last_elem;
    logic [N-1:0][AW-1:0]          a_addr, b_addr;
    logic [N-1:0][WORD_WIDTH-1:0]  a_rd, b_rd;
    logic [0:0][WORD_WIDTH-1:0]    c_rd;
    logic [AW-1:0]                 c_wr_addr;

    assign a_full    = (a_cnt == CW'(NN));
    assign b_full    = (b_cnt == CW'(NN));
    // ld_ack high means the word on the bus was already captured last cycle
    assign ld_take   = (state == ST_LOAD) && ld_stb && !ld_ack && (ld_sel ? !b_full : !a_full);

    assign ip_row_o_stb    = (state == ST_ISSUE) && !row_done;
    assign ip_column_o_stb = (state == ST_ISSUE) && !col_done;
    assign ip_out_o_ack    = (state == ST_WAIT_RES);
    assign res_take        = ip_out_o_ack && ip_out_i_stb;
    assign store           = res_take || wd_fire;
    assign last_pair       = (i_q == JW'(N - 1)) && (j_q == JW'(N - 1));

    assign c_out_stb = (state == ST_DRAIN) && !drain_gap;
    assign c_take    = c_out_stb && c_out_ack;
    assign last_elem = (idx_q == AW'(NN - 1));
    assign busy      = (state != ST_LOAD);

    always_comb begin
        a_addr = '0;
        b_addr = '0;
        for (int k = 0; k < N; k++) begin
            a_addr[k] = AW'(int'(i_q) * N + k);
            b_addr[k] = AW'(k * N + int'(j_q));
        end
    end
    assign c_wr_addr = AW'(int'(i_q) * N + int'(j_q));

    assign ip_row     = ip_row_o_stb    ? a_rd     : '0;
    assign ip_column  = ip_column_o_stb ? b_rd     : '0;
    assign c_out_data = c_out_stb       ? c_rd[0]  : '0;

    matrix_word_buffer #(.N(N), .RP(N)) u_buf_a (
        .clk(clk), .wr_en(ld_take && !ld_sel), .wr_addr(a_cnt[AW-1:0]), .wr_data(ld_data),
        .rd_addr(a_addr), .rd_data(a_rd)
    );
    matrix_word_buffer #(.N(N), .RP(N)) u_buf_b (
        .clk(clk), .wr_en(ld_take && ld_sel), .wr_addr(b_cnt[AW-1:0]), .wr_data(ld_data),
        .rd_addr(b_addr), .rd_data(b_rd)
    );
    matrix_word_buffer #(.N(N), .RP(1)) u_buf_c (
        .clk(clk), .wr_en(store), .wr_addr(c_wr_addr), .wr_data(res_take ? ip_out : FP_QNAN),
        .rd_addr(idx_q), .rd_data(c_rd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:     if (a_full && b_full) state_nxt = ST_ISSUE;
            ST_ISSUE:    if (store) state_nxt = last_pair ? ST_DRAIN : ST_ISSUE;
                         else if (row_done && col_done) state_nxt = ST_WAIT_RES;
            ST_WAIT_RES: if (store) state_nxt = last_pair ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN:    if (c_take && last_elem) state_nxt = ST_LOAD;
            default:     state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            ld_ack    <= 1'b0;
            a_cnt     <= '0;
            b_cnt     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            idx_q     <= '0;
            row_done  <= 1'b0;
            col_done  <= 1'b0;
            drain_gap <= 1'b0;
        end else begin
            state     <= state_nxt;
            ld_ack    <= ld_take;
            drain_gap <= c_take;
            if (ld_take && !ld_sel) a_cnt <= a_cnt + 1'b1;
            if (ld_take &&  ld_sel) b_cnt <= b_cnt + 1'b1;
            if (ip_row_o_stb    && ip_row_i_ack)    row_done <= 1'b1;
            if (ip_column_o_stb && ip_column_i_ack) col_done <= 1'b1;
            // Latches belong to one pair only; a watchdog skip also restarts the issue
            if (store || (state_nxt != ST_ISSUE)) begin
                row_done <= 1'b0;
                col_done <= 1'b0;
            end
            if (store) begin
                if (j_q == JW'(N - 1)) begin
                    j_q <= '0;
                    i_q <= last_pair ? '0 : i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end
            if (c_take) idx_q <= last_elem ? '0 : idx_q + 1'b1;
            if (c_take && last_elem) begin
                a_cnt <= '0;
                b_cnt <= '0;
            end
        end
    end

`ifdef DOT_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          wd_flag, wd_run;

    assign wd_run      = (state == ST_ISSUE) || (state == ST_WAIT_RES);
    assign wd_fire     = wd_run && !res_take && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign dot_timeout = wd_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            wd_cnt <= (store || !wd_run) ? '0 : wd_cnt + 1'b1;
            if (wd_fire) wd_flag <= 1'b1;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign dot_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_dot_scheduler.sv
// Directed bench for matrix_dot_scheduler (N=4) with a behavioural inner-product responder.
module tb_matrix_dot_scheduler;
    localparam int N  = 4;
    localparam int NN = N * N;
`ifdef DOT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic              clk, rst;
    logic [31:0]       ld_data;
    logic              ld_sel, ld_stb, ld_ack;
    logic [32*N-1:0]   ip_row, ip_column;
    logic              ip_row_o_stb, ip_column_o_stb, ip_row_i_ack, ip_column_i_ack;
    logic [31:0]       ip_out;
    logic              ip_out_i_stb, ip_out_o_ack;
    logic [31:0]       c_out_data;
    logic              c_out_stb, c_out_ack, busy, dot_timeout;

    matrix_dot_scheduler #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ld_data(ld_data), .ld_sel(ld_sel), .ld_stb(ld_stb), .ld_ack(ld_ack),
        .ip_row(ip_row), .ip_column(ip_column),
        .ip_row_o_stb(ip_row_o_stb), .ip_column_o_stb(ip_column_o_stb),
        .ip_row_i_ack(ip_row_i_ack), .ip_column_i_ack(ip_column_i_ack),
        .ip_out(ip_out), .ip_out_i_stb(ip_out_i_stb), .ip_out_o_ack(ip_out_o_ack),
        .c_out_data(c_out_data), .c_out_stb(c_out_stb), .c_out_ack(c_out_ack),
        .busy(busy), .dot_timeout(dot_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        real r;
        int  e;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Responder knobs (written by main) and observations (written by responder)
    int   rdly = 0, cdly = 0, hold_pair = -1;
    int   pair_no = 0, withheld_cnt = 0;
    logic skew_row_seen = 1'b1, skew_col_seen = 1'b0;
    int   row_hs = 0, col_hs = 0;

    always @(posedge clk) begin
        if (ip_row_o_stb && ip_row_i_ack) row_hs++;
        if (ip_column_o_stb && ip_column_i_ack) col_hs++;
    end

    initial begin : ip_model
        logic [N-1:0][31:0] r_v, c_v;
        real acc;
        int  mx;
        bit  skew_done;
        skew_done = 1'b0;
        ip_row_i_ack = 1'b0; ip_column_i_ack = 1'b0;
        ip_out = '0; ip_out_i_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (ip_row_o_stb && ip_column_o_stb) begin
                r_v = ip_row;
                c_v = ip_column;
                mx = (rdly > cdly) ? rdly : cdly;
                for (int t = 0; t <= mx; t++) begin
                    ip_row_i_ack    = (t == rdly);
                    ip_column_i_ack = (t == cdly);
                    @(negedge clk);
                    if (!skew_done && t == rdly && rdly < cdly) begin
                        skew_row_seen = ip_row_o_stb;
                        skew_col_seen = ip_column_o_stb;
                        skew_done = 1'b1;
                    end
                end
                ip_row_i_ack = 1'b0; ip_column_i_ack = 1'b0;
                acc = 0.0;
                for (int k = 0; k < N; k++) acc += f2r(r_v[k]) * f2r(c_v[k]);
                if (pair_no == hold_pair) begin
                    withheld_cnt++;
                end else begin
                    repeat (2) @(negedge clk);
                    ip_out = r2f(acc);
                    ip_out_i_stb = 1'b1;
                    for (int w = 0; w < 200 && !ip_out_o_ack; w++) @(negedge clk);
                    @(negedge clk);
                    ip_out_i_stb = 1'b0;
                    ip_out = '0;
                end
                pair_no++;
            end
        end
    end

    task automatic load_mats(input logic [31:0] a[NN], input logic [31:0] b[NN], input bit probe_full);
        int  w;
        bit  seen;
        for (int sel = 0; sel < 2; sel++) begin
            for (int e = 0; e < NN; e++) begin
                ld_sel  = sel[0];
                ld_data = sel[0] ? b[e] : a[e];
                ld_stb  = 1'b1;
                w = 0;
                while (!ld_ack && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                chk("ld_ack_wait", 32'(w < 100), 32'd1);
                @(negedge clk);
            end
            if (sel == 0 && probe_full) begin
                ld_sel = 1'b0;
                ld_data = 32'h3F80_0000;
                seen = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    seen |= ld_ack;
                end
                chk("full_a_stall", 32'(seen), 32'd0);
                ld_stb = 1'b0;
                @(negedge clk);
            end
        end
        ld_stb = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [31:0] exp[NN], input int stall_idx);
        int          w;
        bit          stable;
        logic [31:0] d;
        for (int e = 0; e < NN; e++) begin
            w = 0;
            while (!c_out_stb && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) begin
                chk({tag, "_drain_wait"}, 32'(w), 32'd0);
                return;
            end
            if (e == stall_idx) begin
                d = c_out_data;
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (!c_out_stb || c_out_data !== d) stable = 1'b0;
                end
                chk({tag, "_stall_stable"}, 32'(stable), 32'd1);
            end
            chk($sformatf("%s_c%0d", tag, e), c_out_data, exp[e]);
            c_out_ack = 1'b1;
            @(negedge clk);
            c_out_ack = 1'b0;
        end
    endtask

    logic [31:0] a1[NN], b1[NN], e1[NN], id4[NN], br[NN];
    int hs_r0, hs_c0, w;

    initial begin : main
        for (int k = 0; k < NN; k++) begin
            a1[k] = '0; b1[k] = '0; e1[k] = '0;
            id4[k] = (k % (N + 1) == 0) ? 32'h3F80_0000 : 32'h0;
            br[k]  = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
        end
        // 2x2 example embedded top-left in a zero-padded 4x4
        a1[0] = 32'h3F80_0000; a1[1] = 32'h4000_0000; a1[4] = 32'h4040_0000; a1[5] = 32'h4080_0000;
        b1[0] = 32'h40A0_0000; b1[1] = 32'h40C0_0000; b1[4] = 32'h40E0_0000; b1[5] = 32'h4100_0000;
        e1[0] = 32'h4198_0000; e1[1] = 32'h41B0_0000; e1[4] = 32'h422C_0000; e1[5] = 32'h4248_0000;

        rst = 1'b1; ld_data = '0; ld_sel = 1'b0; ld_stb = 1'b0; c_out_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld_ack", 32'(ld_ack), 32'd0);
        chk("rst_row_stb", 32'(ip_row_o_stb), 32'd0);
        chk("rst_col_stb", 32'(ip_column_o_stb), 32'd0);
        chk("rst_out_ack", 32'(ip_out_o_ack), 32'd0);
        chk("rst_c_stb", 32'(c_out_stb), 32'd0);
        chk("rst_ip_row", 32'(ip_row != '0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Float example; C element 1 back-pressured for 10 cycles
        hs_r0 = row_hs; hs_c0 = col_hs;
        load_mats(a1, b1, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        drain("t1", e1, 1);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_row_hs", 32'(row_hs - hs_r0), 32'd16);
        chk("t1_col_hs", 32'(col_hs - hs_c0), 32'd16);

        // Identity x random B, column ack 3 cycles after row ack, overfull A probe
        rdly = 0; cdly = 3;
        hs_r0 = row_hs; hs_c0 = col_hs;
        load_mats(id4, br, 1'b1);
        drain("t2", br, -1);
        chk("t2_row_hs", 32'(row_hs - hs_r0), 32'd16);
        chk("t2_col_hs", 32'(col_hs - hs_c0), 32'd16);
        chk("t2_skew_row_stb", 32'(skew_row_seen), 32'd0);
        chk("t2_skew_col_stb", 32'(skew_col_seen), 32'd1);
        rdly = 0; cdly = 0;

        // Reset while waiting on the result of pair (1,0)
        hold_pair = pair_no + 4;
        w = withheld_cnt;
        load_mats(a1, b1, 1'b0);
        for (int k = 0; k < 2000 && !(withheld_cnt > w && ip_out_o_ack); k++) @(negedge clk);
        chk("t3_in_wait_res", 32'(ip_out_o_ack), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t3_rst_busy", 32'(busy), 32'd0);
        chk("t3_rst_out_ack", 32'(ip_out_o_ack), 32'd0);
        chk("t3_rst_row_stb", 32'(ip_row_o_stb | ip_column_o_stb), 32'd0);
        chk("t3_rst_c_stb", 32'(c_out_stb), 32'd0);
        rst = 1'b0;
        hold_pair = -1;
        @(negedge clk);
        load_mats(a1, b1, 1'b0);
        drain("t3", e1, -1);

`ifdef DOT_TIMEOUT_EN
        // Result for (0,1) never arrives; watchdog substitutes qNaN
        hold_pair = pair_no + 1;
        e1[1] = 32'h7FC0_0000;
        load_mats(a1, b1, 1'b0);
        drain("t4", e1, -1);
        chk("t4_dot_timeout", 32'(dot_timeout), 32'd1);
        hold_pair = -1;
`else
        chk("dot_timeout_tied", 32'(dot_timeout), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
